// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: reads a one- or two-byte instruction at the PC,
// steps the PC once per byte, and redirects it on a taken jump from execute.
module fetch_seq #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int LONG_BIT = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_en,
  input  logic [AW-1:0] pc_add,
  output logic          pc_inc,
  output logic          pc_ld,
  output logic [AW-1:0] pc_a,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [DW-1:0] ir_op,
  output logic [DW-1:0] ir_arg,
  output logic          ir_valid,
  input  logic          ir_ack,
  input  logic          jmp_valid,
  input  logic [AW-1:0] jmp_target
);

  // Handshake: ir_valid is held in HOLD until ir_ack is seen high at a posedge;
  // ir_op/ir_arg stay stable while ir_valid is high. jmp_valid only counts with ir_ack.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_OP  = 3'd1,
    S_STEP_OP   = 3'd2,
    S_FETCH_ARG = 3'd3,
    S_STEP_ARG  = 3'd4,
    S_HOLD      = 3'd5,
    S_LOAD      = 3'd6
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] op_q, arg_q;
  logic [AW-1:0] pc_a_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      arg_q  <= '0;
      pc_a_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH_OP && mem_ready) begin
        op_q  <= mem_rdata;
        arg_q <= '0;
      end
      if (state == S_FETCH_ARG && mem_ready)
        arg_q <= mem_rdata;
      if (state == S_HOLD && ir_ack && jmp_valid)
        pc_a_q <= jmp_target;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (fetch_en) state_nx = S_FETCH_OP;
      S_FETCH_OP:  if (mem_ready) state_nx = S_STEP_OP;
      // op_q already holds the opcode captured in FETCH_OP
      S_STEP_OP:   state_nx = op_q[LONG_BIT] ? S_FETCH_ARG : S_HOLD;
      S_FETCH_ARG: if (mem_ready) state_nx = S_STEP_ARG;
      S_STEP_ARG:  state_nx = S_HOLD;
      S_HOLD: begin
        if (ir_ack) begin
          if (jmp_valid)     state_nx = S_LOAD;
          else if (fetch_en) state_nx = S_FETCH_OP;
          else               state_nx = S_IDLE;
        end
      end
      S_LOAD:      state_nx = fetch_en ? S_FETCH_OP : S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state register so they never glitch.
  assign mem_req  = (state == S_FETCH_OP) || (state == S_FETCH_ARG);
  assign pc_inc   = (state == S_STEP_OP) || (state == S_STEP_ARG);
  assign pc_ld    = (state == S_LOAD);
  assign ir_valid = (state == S_HOLD);
  assign mem_addr = pc_add;
  assign pc_a     = pc_a_q;
  assign ir_op    = op_q;
  assign ir_arg   = arg_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: models the negedge-updating PC and program memory,
// runs a table of fetch vectors plus directed jump/stall/reset sequences.
module tb_fetch_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_en;
  logic [7:0] pc_add;
  logic       pc_inc;
  logic       pc_ld;
  logic [7:0] pc_a;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic [7:0] ir_op;
  logic [7:0] ir_arg;
  logic       ir_valid;
  logic       ir_ack;
  logic       jmp_valid;
  logic [7:0] jmp_target;

  logic [7:0]  mem [256];
  logic [7:0]  pc_reg;
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int inc_cnt = 0;
  int ld_cnt = 0;
  logic prev_inc = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_seq #(.AW(8), .DW(8), .LONG_BIT(7)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_add(pc_add),
    .pc_inc(pc_inc), .pc_ld(pc_ld), .pc_a(pc_a), .mem_addr(mem_addr),
    .mem_req(mem_req), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ir_op(ir_op), .ir_arg(ir_arg), .ir_valid(ir_valid), .ir_ack(ir_ack),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target)
  );

  assign pc_add    = pc_reg;
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // PC model updates on negedge; command pulse rules checked at the same point.
  always @(negedge clk) begin
    if (pc_inc || pc_ld) begin
      check("inc_ld_exclusive", {31'd0, pc_inc & pc_ld}, 32'd0);
      if (pc_inc) check("inc_not_adjacent", {31'd0, prev_inc}, 32'd0);
    end
    prev_inc = pc_inc;
    if (pc_inc) inc_cnt++;
    if (pc_ld)  ld_cnt++;
    if (pc_ld)       pc_reg = pc_a;
    else if (pc_inc) pc_reg = pc_reg + 8'd1;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b0; ir_ack = 1'b0; jmp_valid = 1'b0;
    jmp_target = 8'h00; mem_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input logic [7:0] arg_addr, output int lat);
    lat = 0;
    while (!ir_valid && lat < 20) begin
      step();
      lat++;
      if (mem_req && inc_cnt == 1) check("fetch_arg_addr", {24'd0, mem_addr}, {24'd0, arg_addr});
    end
    if (!ir_valid) check("ir_valid_timeout", {31'd0, ir_valid}, 32'd1);
  endtask

  task automatic ack_to_idle();
    fetch_en = 1'b0; ir_ack = 1'b1; jmp_valid = 1'b0;
    step();
    ir_ack = 1'b0;
    check("idle_after_ack", {31'd0, ir_valid}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] op;
    logic [7:0] arg;
    logic [7:0] exp_arg;
    logic [7:0] exp_pc;
    int         exp_lat;
    int         exp_incs;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat;
    logic [7:0] a1;
    logic [15:0] exp_ir;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    pc_reg = 8'h00;
    rst = 1'b1; fetch_en = 1'b0; ir_ack = 1'b0; jmp_valid = 1'b0;
    jmp_target = 8'h00; mem_ready = 1'b0;

    vecs[0] = '{8'h00, 8'h12, 8'hEE, 8'h00, 8'h01, 2, 1};
    vecs[1] = '{8'h10, 8'h85, 8'h3C, 8'h3C, 8'h12, 4, 2};
    vecs[2] = '{8'hFF, 8'h90, 8'h5A, 8'h5A, 8'h01, 4, 2};
    vecs[3] = '{8'h40, 8'h7F, 8'hAB, 8'h00, 8'h41, 2, 1};
    vecs[4] = '{8'h80, 8'hFF, 8'h01, 8'h01, 8'h82, 4, 2};

    // ---------------- reset state ----------------
    do_reset();
    check("rst_ir_op",    {24'd0, ir_op},  32'd0);
    check("rst_ir_arg",   {24'd0, ir_arg}, 32'd0);
    check("rst_pc_a",     {24'd0, pc_a},   32'd0);
    check("rst_mem_req",  {31'd0, mem_req},  32'd0);
    check("rst_pc_inc",   {31'd0, pc_inc},   32'd0);
    check("rst_pc_ld",    {31'd0, pc_ld},    32'd0);
    check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, {24'd0, pc_add});

    // ---------------- table-driven fetches ----------------
    for (int v = 0; v < 5; v++) begin
      do_reset();
      pc_reg = vecs[v].addr;
      a1 = vecs[v].addr + 8'd1;
      mem[vecs[v].addr] = vecs[v].op;
      mem[a1] = vecs[v].arg;
      exp_q.push_back({vecs[v].op, vecs[v].exp_arg});
      inc_cnt = 0; ld_cnt = 0;
      fetch_en = 1'b1; mem_ready = 1'b1;
      step();
      check("op_req", {31'd0, mem_req}, 32'd1);
      check("op_addr", {24'd0, mem_addr}, {24'd0, vecs[v].addr});
      wait_valid(a1, lat);
      exp_ir = exp_q.pop_front();
      check("latency", lat, vecs[v].exp_lat);
      check("ir_op", {24'd0, ir_op}, {24'd0, exp_ir[15:8]});
      check("ir_arg", {24'd0, ir_arg}, {24'd0, exp_ir[7:0]});
      check("pc_at_hold", {24'd0, pc_add}, {24'd0, vecs[v].exp_pc});
      check("inc_pulses", inc_cnt, vecs[v].exp_incs);
      check("no_ld", ld_cnt, 0);
      if (v == 1) begin
        // Jump from HOLD: one pc_ld with target, then fetch at target.
        ir_ack = 1'b1; jmp_valid = 1'b1; jmp_target = 8'hA0;
        inc_cnt = 0;
        step();
        ir_ack = 1'b0; jmp_valid = 1'b0;
        check("jmp_pc_ld", {31'd0, pc_ld}, 32'd1);
        check("jmp_pc_a", {24'd0, pc_a}, 32'hA0);
        check("jmp_ir_valid", {31'd0, ir_valid}, 32'd0);
        mem_ready = 1'b0;
        step();
        check("jmp_ld_once", {31'd0, pc_ld}, 32'd0);
        check("jmp_req", {31'd0, mem_req}, 32'd1);
        check("jmp_addr", {24'd0, mem_addr}, 32'hA0);
        check("jmp_ld_cnt", ld_cnt, 1);
        check("jmp_no_inc", inc_cnt, 0);
      end else begin
        ack_to_idle();
      end
    end

    // ---------------- delayed mem_ready ----------------
    do_reset();
    pc_reg = 8'h20; mem[8'h20] = 8'h33;
    inc_cnt = 0;
    fetch_en = 1'b1; mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("stall_req", {31'd0, mem_req}, 32'd1);
      check("stall_ir_op", {24'd0, ir_op}, 32'd0);
      check("stall_no_inc", inc_cnt, 0);
      step();
    end
    check("stall_req_4th", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1;
    step();
    check("stall_captured", {24'd0, ir_op}, 32'h33);
    check("stall_step_inc", {31'd0, pc_inc}, 32'd1);
    check("stall_step_noreq", {31'd0, mem_req}, 32'd0);
    step();
    check("stall_hold", {31'd0, ir_valid}, 32'd1);
    check("stall_pc", {24'd0, pc_add}, 32'h21);
    ack_to_idle();

    // ---------------- reset during FETCH_ARG ----------------
    do_reset();
    pc_reg = 8'h50; mem[8'h50] = 8'hC4; mem[8'h51] = 8'h77;
    fetch_en = 1'b1; mem_ready = 1'b1;
    step();                       // FETCH_OP
    step();                       // STEP_OP
    mem_ready = 1'b0;
    step();                       // FETCH_ARG
    check("farg_req", {31'd0, mem_req}, 32'd1);
    check("farg_addr", {24'd0, mem_addr}, 32'h51);
    rst = 1'b1; mem_ready = 1'b1;
    step();
    rst = 1'b0; fetch_en = 1'b0;
    check("midrst_req", {31'd0, mem_req}, 32'd0);
    check("midrst_valid", {31'd0, ir_valid}, 32'd0);
    check("midrst_ir_op", {24'd0, ir_op}, 32'd0);
    check("midrst_ir_arg", {24'd0, ir_arg}, 32'd0);
    step();
    check("midrst_stays_idle", {31'd0, mem_req}, 32'd0);

    // ---------------- jmp_valid without ack is ignored ----------------
    pc_reg = 8'h60; mem[8'h60] = 8'h05;
    ld_cnt = 0;
    fetch_en = 1'b1; mem_ready = 1'b1;
    step();
    wait_valid(8'h61, lat);
    check("noack_lat", lat, 2);
    jmp_valid = 1'b1; jmp_target = 8'hC0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("noack_valid", {31'd0, ir_valid}, 32'd1);
      check("noack_no_ld", {31'd0, pc_ld}, 32'd0);
      check("noack_ir_op", {24'd0, ir_op}, 32'h05);
    end
    check("noack_ld_cnt", ld_cnt, 0);
    jmp_valid = 1'b0;
    ack_to_idle();

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
